// File: rtl/uart_rx_frame_check_if.sv
// Bus between the RX FSM/edge counter and the parity/stop-bit frame checker.
// master drives the sampling window and frame context; slave returns the error status.
interface uart_rx_frame_check_if #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  parameter int CNT_W   = 8
);
  logic               rx_in;
  logic [PRESC_W-1:0] Prescale;
  logic [PRESC_W-1:0] edge_count;
  logic               par_check_en;
  logic               stp_check_en;
  logic [1:0]         PAR_MODE;
  logic [DATA_W-1:0]  P_data;
  logic               err_clr;
  logic               par_error;
  logic               stp_error;
  logic               err_pulse;
  logic [CNT_W-1:0]   par_err_cnt;
  logic [CNT_W-1:0]   stp_err_cnt;
  logic [1:0]         dbg_state;

  // Handshake: there is no valid/ready pair. A window is open while par_check_en
  // or stp_check_en is high; err_pulse is a one-cycle strobe that is never back-pressured.
  modport master (
    output rx_in, Prescale, edge_count, par_check_en, stp_check_en, PAR_MODE, P_data, err_clr,
    input  par_error, stp_error, err_pulse, par_err_cnt, stp_err_cnt, dbg_state
  );
  modport slave (
    input  rx_in, Prescale, edge_count, par_check_en, stp_check_en, PAR_MODE, P_data, err_clr,
    output par_error, stp_error, err_pulse, par_err_cnt, stp_err_cnt, dbg_state
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX parity/stop-bit checker: 3-sample majority vote at mid-bit, sticky error flags, strobe.
// Saturating error counters exist only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_check #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_frame_check_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mode_par, w_mode_par_nxt;
  logic               r_par_error, w_par_error_nxt;
  logic               r_stp_error, w_stp_error_nxt;
  logic               r_err_pulse, w_err_pulse_nxt;
  logic               r_s0, r_s1, r_s2;
  logic [PRESC_W-1:0] w_mid, w_mid_m1, w_mid_p1, w_mid_p2;
  logic               w_any_en, w_vote, w_exp_par, w_mismatch;

  assign w_mid    = bus.Prescale >> 1;
  assign w_mid_m1 = w_mid - PRESC_W'(1);
  assign w_mid_p1 = w_mid + PRESC_W'(1);
  assign w_mid_p2 = w_mid + PRESC_W'(2);
  assign w_any_en = bus.par_check_en | bus.stp_check_en;

  // Samples track the edge counter unconditionally; only the decision cycle consumes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      if (bus.edge_count == w_mid_m1) r_s0 <= bus.rx_in;
      if (bus.edge_count == w_mid)    r_s1 <= bus.rx_in;
      if (bus.edge_count == w_mid_p1) r_s2 <= bus.rx_in;
    end
  end

  assign w_vote = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);

  always_comb begin
    w_exp_par = 1'b0;
    case (bus.PAR_MODE)
      2'b00:   w_exp_par = ^bus.P_data;
      2'b01:   w_exp_par = ~^bus.P_data;
      2'b10:   w_exp_par = 1'b1;
      default: w_exp_par = 1'b0;
    endcase
  end

  assign w_mismatch = r_mode_par ? (w_vote != w_exp_par) : ~w_vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mode_par  <= 1'b0;
      r_par_error <= 1'b0;
      r_stp_error <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode_par  <= w_mode_par_nxt;
      r_par_error <= w_par_error_nxt;
      r_stp_error <= w_stp_error_nxt;
      r_err_pulse <= w_err_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_par_nxt  = r_mode_par;
    w_par_error_nxt = r_par_error;
    w_stp_error_nxt = r_stp_error;
    w_err_pulse_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_par_error_nxt = 1'b0;
        w_stp_error_nxt = 1'b0;
        if (w_any_en) begin
          w_state_nxt    = ST_SAMPLE;
          w_mode_par_nxt = bus.par_check_en;
        end
      end
      ST_SAMPLE: begin
        // A window that closes before the decision edge is discarded silently.
        if (!w_any_en) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.edge_count == w_mid_p2) begin
          w_state_nxt     = ST_HOLD;
          w_par_error_nxt = r_mode_par & w_mismatch;
          w_stp_error_nxt = ~r_mode_par & w_mismatch;
          w_err_pulse_nxt = w_mismatch;
        end
      end
      ST_HOLD: begin
        if (!w_any_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.par_error = r_par_error;
  assign bus.stp_error = r_stp_error;
  assign bus.err_pulse = r_err_pulse;
  assign bus.dbg_state = r_state;

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_W-1:0] r_par_err_cnt, r_stp_err_cnt;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err_cnt <= '0;
      r_stp_err_cnt <= '0;
    end else if (bus.err_clr) begin
      r_par_err_cnt <= '0;
      r_stp_err_cnt <= '0;
    end else begin
      if (r_err_pulse && r_par_error && (r_par_err_cnt != '1))
        r_par_err_cnt <= r_par_err_cnt + CNT_W'(1);
      if (r_err_pulse && r_stp_error && (r_stp_err_cnt != '1))
        r_stp_err_cnt <= r_stp_err_cnt + CNT_W'(1);
    end
  end

  assign bus.par_err_cnt = r_par_err_cnt;
  assign bus.stp_err_cnt = r_stp_err_cnt;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign bus.par_err_cnt  = '0;
  assign bus.stp_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: directed vector table, hand sequences and randomized windows
// checked against a spec-level model of vote, parity and saturating counters.
module tb_uart_rx_frame_check;

  localparam int DATA_W  = 8;
  localparam int PRESC_W = 6;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  uart_rx_frame_check_if #(.DATA_W(DATA_W), .PRESC_W(PRESC_W), .CNT_W(CNT_W)) bus ();

  uart_rx_frame_check #(.DATA_W(DATA_W), .PRESC_W(PRESC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int m_par_cnt = 0;
  int m_stp_cnt = 0;

  task automatic check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Expected observation word: {par_flag, stp_flag, pulse_count[1:0], par_cnt, stp_cnt}.
  task automatic sb_expect(input bit is_par, input logic err, input int clr_at, input int cap);
    logic [1:0] pc, sc;
    if (CNT_EN) begin
      if (clr_at >= 0 && clr_at < cap) begin m_par_cnt = 0; m_stp_cnt = 0; end
      if (err && is_par)  m_par_cnt = sat_inc(m_par_cnt);
      if (err && !is_par) m_stp_cnt = sat_inc(m_stp_cnt);
      if (clr_at >= cap) begin m_par_cnt = 0; m_stp_cnt = 0; end
    end
    pc = 2'(m_par_cnt);
    sc = 2'(m_stp_cnt);
    exp_q.push_back({is_par & err, ~is_par & err, 1'b0, err, pc, sc});
  endtask

  task automatic sb_check(input string name, input logic [7:0] obs);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check_eq({name, "_noexp"}, 16'(obs), 16'hffff);
    end else begin
      e = exp_q.pop_front();
      check_eq(name, 16'(obs), 16'(e));
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic model_err(input bit pen, input bit sen, input int presc,
                                     input logic [1:0] mode, input logic [7:0] data,
                                     input logic [31:0] line, input int drop_at);
    int mid, ones;
    logic voted, expect_bit;
    mid = presc / 2;
    if (!pen && !sen) return 1'b0;
    if (drop_at <= mid + 2) return 1'b0;
    ones  = int'(line[mid-1]) + int'(line[mid]) + int'(line[mid+1]);
    voted = (ones >= 2);
    if (pen) begin
      case (mode)
        2'b00:   expect_bit = ($countones(data) % 2) == 1;
        2'b01:   expect_bit = ($countones(data) % 2) == 0;
        2'b10:   expect_bit = 1'b1;
        default: expect_bit = 1'b0;
      endcase
    end else begin
      expect_bit = 1'b1;
    end
    return voted != expect_bit;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.rx_in        = 1'b1;
    bus.edge_count   = '0;
    bus.par_check_en = 1'b0;
    bus.stp_check_en = 1'b0;
    bus.err_clr      = 1'b0;
  endtask

  // One bit window of presc cycles followed by 3 idle cycles.
  task automatic run_window(input bit pen, input bit sen, input int presc, input logic [1:0] mode,
                            input logic [7:0] data, input logic [31:0] line, input int drop_at,
                            input int clr_at, input string name);
    int mid, cap, pulses;
    logic pf, sf, pf_end, sf_end;
    mid = presc / 2;
    cap = mid + 3;
    pulses = 0;
    pf = 1'b0; sf = 1'b0; pf_end = 1'b0; sf_end = 1'b0;
    bus.P_data   = data;
    bus.PAR_MODE = mode;
    bus.Prescale = PRESC_W'(presc);
    for (int c = 0; c < presc + 3; c++) begin
      @(posedge clk); #1;
      if (c < presc) begin
        bus.edge_count   = PRESC_W'(c);
        bus.rx_in        = line[c];
        bus.par_check_en = pen && (c < drop_at);
        bus.stp_check_en = sen && (c < drop_at);
      end else begin
        idle_inputs();
      end
      bus.err_clr = (c == clr_at);
      @(negedge clk);
      if (bus.err_pulse) pulses++;
      if (c == cap) begin pf = bus.par_error; sf = bus.stp_error; end
      if (c == presc - 1) begin pf_end = bus.par_error; sf_end = bus.stp_error; end
    end
    sb_check(name, {pf, sf, 2'(pulses), bus.par_err_cnt, bus.stp_err_cnt});
    if (cap <= presc - 1) check_eq({name, "_hold"}, 16'({pf_end, sf_end}), 16'({pf, sf}));
    check_eq({name, "_clr"}, 16'({bus.par_error, bus.stp_error, bus.err_pulse}), 16'h0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string       name;
    bit          pen;
    bit          sen;
    int          presc;
    logic [1:0]  mode;
    logic [7:0]  data;
    logic [31:0] line;
    int          drop_at;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    idle_inputs();
    bus.Prescale = 6'd8;
    bus.PAR_MODE = 2'b00;
    bus.P_data   = 8'h00;

    vecs[0] = '{"even_ok",    1, 0,  8, 2'b00, 8'hA5, 32'h0000_0000, 99, 1'b0};
    vecs[1] = '{"odd_err",    1, 0,  8, 2'b01, 8'hA5, 32'h0000_0000, 99, 1'b1};
    vecs[2] = '{"stp_glitch", 0, 1,  8, 2'b00, 8'h00, 32'hFFFF_FFEF, 99, 1'b0};
    vecs[3] = '{"stp_low",    0, 1,  8, 2'b00, 8'h00, 32'h0000_0000, 99, 1'b1};
    vecs[4] = '{"mark_ok",    1, 0,  8, 2'b10, 8'h3C, 32'hFFFF_FFFF, 99, 1'b0};
    vecs[5] = '{"space_err",  1, 0,  8, 2'b11, 8'h3C, 32'hFFFF_FFFF, 99, 1'b1};
    vecs[6] = '{"even_vote1", 1, 0,  8, 2'b00, 8'h01, 32'h0000_0028, 99, 1'b0};
    vecs[7] = '{"par_abort",  1, 0,  8, 2'b00, 8'hA5, 32'hFFFF_FFFF,  3, 1'b0};
    vecs[8] = '{"both_en",    1, 1,  8, 2'b00, 8'hA5, 32'hFFFF_FFFF, 99, 1'b1};
    vecs[9] = '{"stp_2glit",  0, 1, 12, 2'b00, 8'h00, 32'hFFFF_FF5F, 99, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", 16'({bus.par_error, bus.stp_error, bus.err_pulse, bus.dbg_state,
                                 bus.par_err_cnt, bus.stp_err_cnt}), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_reset", 16'({bus.par_error, bus.stp_error, bus.err_pulse, bus.dbg_state}), 16'h0);

    foreach (vecs[i]) begin
      sb_expect(vecs[i].pen, vecs[i].exp_err, -1, vecs[i].presc / 2 + 3);
      run_window(vecs[i].pen, vecs[i].sen, vecs[i].presc, vecs[i].mode, vecs[i].data,
                 vecs[i].line, vecs[i].drop_at, -1, vecs[i].name);
    end

    // Clear counters, then saturate the framing counter with five bad stop bits.
    @(posedge clk); #1;
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    m_par_cnt = 0;
    m_stp_cnt = 0;
    @(negedge clk);
    check_eq("clr_idle", 16'({bus.par_err_cnt, bus.stp_err_cnt}), 16'h0);
    for (int k = 0; k < 5; k++) begin
      sb_expect(1'b0, 1'b1, -1, 7);
      run_window(1'b0, 1'b1, 8, 2'b00, 8'h00, 32'h0, 99, -1, $sformatf("sat_%0d", k));
    end
    check_eq("sat_value", 16'(bus.stp_err_cnt), CNT_EN ? 16'(CNT_MAX) : 16'h0);

    // Clear landing in the same cycle as an increment must win.
    sb_expect(1'b0, 1'b1, -1, 7);
    run_window(1'b0, 1'b1, 8, 2'b00, 8'h00, 32'h0, 99, -1, "pre_clr_inc");
    sb_expect(1'b0, 1'b1, 7, 7);
    run_window(1'b0, 1'b1, 8, 2'b00, 8'h00, 32'h0, 99, 7, "clr_vs_inc");

    // Reset while holding an error flag clears everything immediately.
    bus.Prescale = 6'd8;
    bus.PAR_MODE = 2'b01;
    bus.P_data   = 8'hA5;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      bus.edge_count   = PRESC_W'(c);
      bus.rx_in        = 1'b0;
      bus.par_check_en = 1'b1;
    end
    @(negedge clk);
    check_eq("hold_flag", 16'({bus.par_error, bus.dbg_state}), 16'({1'b1, 2'd2}));
    #1 rst = 1'b1;
    #1;
    check_eq("rst_in_hold", 16'({bus.par_error, bus.stp_error, bus.err_pulse, bus.dbg_state,
                                 bus.par_err_cnt, bus.stp_err_cnt}), 16'h0);
    idle_inputs();
    m_par_cnt = 0;
    m_stp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized windows against the model.
    for (int n = 0; n < 40; n++) begin
      bit pen, sen;
      int presc, drop_at;
      logic [1:0] mode;
      logic [7:0] data;
      logic [31:0] line;
      logic err;
      pen = 1'($urandom_range(0, 1));
      sen = !pen || ($urandom_range(0, 7) == 0);
      presc = 2 * $urandom_range(3, 10);
      mode = 2'($urandom_range(0, 3));
      data = 8'($urandom);
      line = $urandom;
      drop_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, presc / 2 + 1) : 99;
      err = model_err(pen, sen, presc, mode, data, line, drop_at);
      sb_expect(pen, err, -1, presc / 2 + 3);
      run_window(pen, sen, presc, mode, data, line, drop_at, -1, $sformatf("rand_%0d", n));
    end

    check_eq("sb_empty", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
